// File: rtl/async_fifo_rd_ctrl_fwft_pkg.sv
// ---------------------------------------------------------------------------
// async_fifo_rd_ctrl_fwft_pkg
// Shared definitions for the read side of the async FIFO.
//   BUF_DEPTH  : number of entries in the FWFT output buffer
//   buf_op_e   : per-cycle operation applied to the output buffer,
//                encoded as {push, pop}
// ---------------------------------------------------------------------------
package async_fifo_rd_ctrl_fwft_pkg;

    localparam logic [1:0] BUF_DEPTH = 2'd2;

    typedef enum logic [1:0] {
        BUF_IDLE     = 2'b00,
        BUF_POP      = 2'b01,
        BUF_PUSH     = 2'b10,
        BUF_PUSH_POP = 2'b11
    } buf_op_e;

endpackage

// File: rtl/bin2gray.sv
// ---------------------------------------------------------------------------
// bin2gray
// Combinational binary to gray-code conversion.
//   bin  : binary input value
//   gray : gray-coded output value
// ---------------------------------------------------------------------------
module bin2gray #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray
);

    assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/fifo_fwft_out_buf.sv
// ---------------------------------------------------------------------------
// fifo_fwft_out_buf
// Two-entry first-word-fall-through output buffer behind a RAM with one
// cycle of read latency.
//   clk       : clock
//   rst       : synchronous active-high reset (drops buffered/in-flight data)
//   issue     : a RAM read is issued this cycle; its data arrives next cycle
//   push_data : RAM read data, captured when a read was issued last cycle
//   pop_ready : consumer ready
//   space     : a new read may be issued without overflowing the buffer
//   m_data    : oldest buffered word (holds last value while empty)
//   m_valid   : buffer holds at least one word
// ---------------------------------------------------------------------------
module fifo_fwft_out_buf
    import async_fifo_rd_ctrl_fwft_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop_ready,
    output logic                  space,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid
);

    logic [1:0]            occ_q, occ_d;
    logic                  in_flight_q, in_flight_d;
    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic [DATA_WIDTH-1:0] tail_q, tail_d;
    logic                  pop_s;
    logic [2:0]            pending_s;
    buf_op_e               op_s;

    assign pop_s = (occ_q != 2'd0) && pop_ready;
    assign op_s  = buf_op_e'({in_flight_q, pop_s});

    // Words held or already on their way, after this cycle's pop. Never
    // negative because a pop requires occ_q >= 1.
    assign pending_s = {1'b0, occ_q} + {2'b00, in_flight_q} - {2'b00, pop_s};
    assign space     = (pending_s < {1'b0, BUF_DEPTH});

    // Next-state for occupancy, entries and the in-flight flag.
    always_comb begin
        occ_d       = occ_q;
        head_d      = head_q;
        tail_d      = tail_q;
        in_flight_d = issue;
        case (op_s)
            BUF_PUSH: begin
                if (occ_q == 2'd0) begin
                    head_d = push_data;
                    occ_d  = 2'd1;
                end else if (occ_q == 2'd1) begin
                    tail_d = push_data;
                    occ_d  = BUF_DEPTH;
                end else begin
                    occ_d  = occ_q;
                end
            end
            BUF_POP: begin
                // With a single entry the head keeps its value so m_data
                // holds the last word while the buffer is empty.
                if (occ_q == BUF_DEPTH) begin
                    head_d = tail_q;
                    occ_d  = 2'd1;
                end else begin
                    occ_d  = 2'd0;
                end
            end
            BUF_PUSH_POP: begin
                if (occ_q == BUF_DEPTH) begin
                    head_d = tail_q;
                    tail_d = push_data;
                end else begin
                    head_d = push_data;
                end
            end
            default: begin
                occ_d = occ_q;
            end
        endcase
    end

    // Buffer state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q       <= 2'd0;
            in_flight_q <= 1'b0;
            head_q      <= {DATA_WIDTH{1'b0}};
            tail_q      <= {DATA_WIDTH{1'b0}};
        end else begin
            occ_q       <= occ_d;
            in_flight_q <= in_flight_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
        end
    end

    assign m_data  = head_q;
    assign m_valid = (occ_q != 2'd0);

endmodule

// File: rtl/gray2bin.sv
// ---------------------------------------------------------------------------
// gray2bin
// Combinational gray-code to binary conversion.
//   gray : gray-coded input value
//   bin  : binary output value
// ---------------------------------------------------------------------------
module gray2bin #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    // Each binary bit is the XOR of all gray bits at or above its position.
    always_comb begin
        bin = {WIDTH{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            bin[i] = ^(gray >> i);
        end
    end

endmodule

// File: rtl/slow2fast_sync_module.sv
// ---------------------------------------------------------------------------
// slow2fast_sync_module
// Two-flop synchroniser for a multi-bit gray-coded bus (only one bit changes
// per source update, so per-bit synchronisation is safe).
//   clk   : destination clock
//   rst   : synchronous active-high reset
//   d_in  : asynchronous input bus
//   d_out : synchronised output bus (2 destination edges of latency)
// ---------------------------------------------------------------------------
module slow2fast_sync_module #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] d_out
);

    logic [WIDTH-1:0] meta_q, meta_d;
    logic [WIDTH-1:0] sync_q, sync_d;

    // Next-state for the two synchroniser stages.
    always_comb begin
        meta_d = d_in;
        sync_d = meta_q;
    end

    // Synchroniser flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= {WIDTH{1'b0}};
            sync_q <= {WIDTH{1'b0}};
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign d_out = sync_q;

endmodule

// File: rtl/async_fifo_rd_ctrl_fwft.sv
// ---------------------------------------------------------------------------
// async_fifo_rd_ctrl_fwft
// Read-side controller of the async FIFO, running in the read clock domain.
//   rd_clk, rd_rst : read clock, synchronous active-high reset
//   wraddr_gray    : gray write pointer from the write domain
//   rdaddr         : binary read pointer (RAM address = low bits)
//   rdaddr_gray    : registered gray read pointer for the write side
//   ram_rd_en      : RAM read strobe (data returns one cycle later)
//   ram_rd_data    : RAM read data
//   m_data/m_valid/m_ready : FWFT output handshake
//   empty          : no word available to the consumer
//   prog_empty     : RAM word count at or below PROG_EMPTY_THRESH
//   rd_count       : unread words still in RAM
// ---------------------------------------------------------------------------
module async_fifo_rd_ctrl_fwft #(
    parameter int RAM_ADDR_WIDTH    = 8,
    parameter int DATA_WIDTH        = 8,
    parameter int PROG_EMPTY_THRESH = 4
) (
    input  logic                      rd_clk,
    input  logic                      rd_rst,
    input  logic [RAM_ADDR_WIDTH-1:0] wraddr_gray,
    output logic [RAM_ADDR_WIDTH-1:0] rdaddr,
    output logic [RAM_ADDR_WIDTH-1:0] rdaddr_gray,
    output logic                      ram_rd_en,
    input  logic [DATA_WIDTH-1:0]     ram_rd_data,
    output logic [DATA_WIDTH-1:0]     m_data,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic                      empty,
    output logic                      prog_empty,
    output logic [RAM_ADDR_WIDTH-1:0] rd_count
);

    localparam logic [RAM_ADDR_WIDTH-1:0] THRESH  = RAM_ADDR_WIDTH'(PROG_EMPTY_THRESH);
    localparam logic [RAM_ADDR_WIDTH-1:0] PTR_ONE = {{(RAM_ADDR_WIDTH-1){1'b0}}, 1'b1};

    logic [RAM_ADDR_WIDTH-1:0] wr_gray_sync_s;
    logic [RAM_ADDR_WIDTH-1:0] wr_bin_q, wr_bin_d;
    logic [RAM_ADDR_WIDTH-1:0] rdaddr_q, rdaddr_d;
    logic [RAM_ADDR_WIDTH-1:0] rdaddr_gray_q, rdaddr_gray_d;
    logic                      ram_empty_s;
    logic                      space_s;
    logic                      ram_rd_en_s;
    logic                      m_valid_s;

    slow2fast_sync_module #(.WIDTH(RAM_ADDR_WIDTH)) u_wr_sync (
        .clk   (rd_clk),
        .rst   (rd_rst),
        .d_in  (wraddr_gray),
        .d_out (wr_gray_sync_s)
    );

    gray2bin #(.WIDTH(RAM_ADDR_WIDTH)) u_wr_g2b (
        .gray (wr_gray_sync_s),
        .bin  (wr_bin_d)
    );

    bin2gray #(.WIDTH(RAM_ADDR_WIDTH)) u_rd_b2g (
        .bin  (rdaddr_q),
        .gray (rdaddr_gray_d)
    );

    // The wrap bit makes equal pointers mean empty and the plain modular
    // difference the word count.
    assign ram_empty_s = (rdaddr_q == wr_bin_q);
    assign rd_count    = wr_bin_q - rdaddr_q;
    assign prog_empty  = (rd_count <= THRESH);
    assign ram_rd_en_s = !ram_empty_s && space_s;

    // Read pointer advances on every issued RAM read.
    always_comb begin
        if (ram_rd_en_s) begin
            rdaddr_d = rdaddr_q + PTR_ONE;
        end else begin
            rdaddr_d = rdaddr_q;
        end
    end

    // Pointer registers.
    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            wr_bin_q      <= {RAM_ADDR_WIDTH{1'b0}};
            rdaddr_q      <= {RAM_ADDR_WIDTH{1'b0}};
            rdaddr_gray_q <= {RAM_ADDR_WIDTH{1'b0}};
        end else begin
            wr_bin_q      <= wr_bin_d;
            rdaddr_q      <= rdaddr_d;
            rdaddr_gray_q <= rdaddr_gray_d;
        end
    end

    fifo_fwft_out_buf #(.DATA_WIDTH(DATA_WIDTH)) u_out_buf (
        .clk       (rd_clk),
        .rst       (rd_rst),
        .issue     (ram_rd_en_s),
        .push_data (ram_rd_data),
        .pop_ready (m_ready),
        .space     (space_s),
        .m_data    (m_data),
        .m_valid   (m_valid_s)
    );

    assign rdaddr      = rdaddr_q;
    assign rdaddr_gray = rdaddr_gray_q;
    assign ram_rd_en   = ram_rd_en_s;
    assign m_valid     = m_valid_s;
    assign empty       = !m_valid_s;

endmodule

// File: tb/tb_async_fifo_rd_ctrl_fwft.sv
// ---------------------------------------------------------------------------
// tb_async_fifo_rd_ctrl_fwft
// Directed/randomised bench for the FIFO read controller. A RAM with one
// cycle of read latency is emulated here; the expected behaviour comes from
// a queue-based model of the FIFO (write pointer delay line, read pointer,
// queue of words presented to the consumer, one pending RAM read).
// ---------------------------------------------------------------------------
module tb_async_fifo_rd_ctrl_fwft;

    logic       clk = 1'b0;
    logic       rd_rst;
    logic [7:0] wraddr_gray;
    logic [7:0] rdaddr;
    logic [7:0] rdaddr_gray;
    logic       ram_rd_en;
    logic [7:0] ram_rd_data = 8'h00;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic       empty;
    logic       prog_empty;
    logic [7:0] rd_count;

    logic [7:0] mem [0:127];

    int checks = 0;
    int errors = 0;

    // reference model state
    int         wptr;
    int         d1, d2, wbin;
    int         rptr, rptr_prev;
    int         pend, pend_addr;
    logic [7:0] outq[$];
    logic [7:0] last_data;
    logic       log_rd;
    int         rd_log[$];

    async_fifo_rd_ctrl_fwft #(
        .RAM_ADDR_WIDTH    (8),
        .DATA_WIDTH        (8),
        .PROG_EMPTY_THRESH (4)
    ) dut (
        .rd_clk      (clk),
        .rd_rst      (rd_rst),
        .wraddr_gray (wraddr_gray),
        .rdaddr      (rdaddr),
        .rdaddr_gray (rdaddr_gray),
        .ram_rd_en   (ram_rd_en),
        .ram_rd_data (ram_rd_data),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .empty       (empty),
        .prog_empty  (prog_empty),
        .rd_count    (rd_count)
    );

    always #5 clk = ~clk;

    // RAM emulation: registered read, one cycle of latency.
    always @(posedge clk) begin
        if (ram_rd_en) ram_rd_data <= mem[rdaddr[6:0]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        d1 = 0; d2 = 0; wbin = 0;
        rptr = 0; rptr_prev = 0;
        pend = 0; pend_addr = 0;
        outq.delete();
        last_data = 8'h00;
    endtask

    // One clock cycle: drive write pointer, check at negedge, advance model.
    task automatic tick();
        int pop, re, cnt, exp_gray;
        logic [7:0] exp_data;
        wraddr_gray = 8'(wptr ^ (wptr >> 1));
        @(negedge clk);
        pop      = (outq.size() > 0 && m_ready) ? 1 : 0;
        re       = (rptr != wbin && (outq.size() + pend - pop) < 2) ? 1 : 0;
        cnt      = (wbin - rptr) & 255;
        exp_gray = rptr_prev ^ (rptr_prev >> 1);
        exp_data = (outq.size() > 0) ? outq[0] : last_data;
        chk("rdaddr",      32'(rdaddr),      32'(rptr));
        chk("rdaddr_gray", 32'(rdaddr_gray), 32'(exp_gray));
        chk("ram_rd_en",   32'(ram_rd_en),   32'(re));
        chk("m_valid",     32'(m_valid),     32'(outq.size() > 0));
        chk("empty",       32'(empty),       32'(outq.size() == 0));
        chk("m_data",      32'(m_data),      32'(exp_data));
        chk("rd_count",    32'(rd_count),    32'(cnt));
        chk("prog_empty",  32'(prog_empty),  32'(cnt <= 4));
        if (log_rd && ram_rd_en) rd_log.push_back(int'(rdaddr));
        @(posedge clk);
        if (rd_rst) begin
            model_reset();
        end else begin
            if (pop != 0) last_data = outq.pop_front();
            if (pend != 0) outq.push_back(mem[pend_addr]);
            pend = re;
            if (re != 0) pend_addr = rptr & 127;
            rptr_prev = rptr;
            if (re != 0) rptr = (rptr + 1) & 255;
            wbin = d2;
            d2   = d1;
            d1   = wptr;
        end
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 8'($urandom);
        log_rd  = 1'b0;
        wptr    = 0;
        m_ready = 1'b0;
        rd_rst  = 1'b1;
        wraddr_gray = 8'h00;
        model_reset();
        repeat (2) @(posedge clk);
        #1;

        // 1: idle after reset, pointer at 0
        tick();
        rd_rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            m_ready = 1'($urandom_range(0, 1));
            tick();
        end

        // 2: one word, consumer not ready; read issued after 3 edges
        m_ready = 1'b0;
        wptr = 1;
        repeat (3) tick();
        chk("lat_rd_en", 32'(ram_rd_en), 32'd1);
        repeat (2) tick();
        chk("lat_m_valid", 32'(m_valid), 32'd1);
        chk("lat_m_data", 32'(m_data), 32'(mem[0]));
        repeat (5) tick();

        // 3: up to 6 words with consumer always ready
        m_ready = 1'b1;
        for (int w = 2; w <= 6; w++) begin
            wptr = w;
            tick();
        end
        repeat (12) tick();

        // 4: up to 10 words with ready toggling
        for (int w = 7; w <= 10; w++) begin
            wptr = w;
            m_ready = ~m_ready;
            tick();
        end
        for (int i = 0; i < 24; i++) begin
            m_ready = ~m_ready;
            tick();
        end

        // random traffic bringing the pointers to 0x7E
        for (int i = 0; i < 2000 && wptr < 8'h7E; i++) begin
            m_ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) wptr = wptr + 1;
            tick();
        end
        m_ready = 1'b1;
        for (int i = 0; i < 200 && !(rptr == 8'h7E && outq.size() == 0 && pend == 0); i++) tick();
        repeat (4) tick();
        chk("wrap_start_rdaddr", 32'(rdaddr), 32'h7E);

        // 5: wrap of the RAM address through 0x7F -> 0x00
        log_rd = 1'b1;
        for (int w = 8'h7F; w <= 8'h82; w++) begin
            wptr = w;
            tick();
        end
        repeat (10) tick();
        log_rd = 1'b0;
        chk("wrap_rdaddr", 32'(rdaddr), 32'h82);
        chk("wrap_empty", 32'(empty), 32'd1);
        chk("wrap_rd_count", 32'(rd_count), 32'd0);
        chk("wrap_reads", 32'(rd_log.size()), 32'd4);
        if (rd_log.size() == 4) begin
            chk("wrap_addr0", 32'(rd_log[0] & 127), 32'h7E);
            chk("wrap_addr1", 32'(rd_log[1] & 127), 32'h7F);
            chk("wrap_addr2", 32'(rd_log[2] & 127), 32'h00);
            chk("wrap_addr3", 32'(rd_log[3] & 127), 32'h01);
        end

        // 6: reset with a buffered word and a read in flight
        m_ready = 1'b0;
        for (int i = 0; i < 40 && !(outq.size() == 1 && pend == 1); i++) begin
            if (wptr < 8'h8A) wptr = wptr + 1;
            tick();
        end
        chk("pre_reset_m_valid", 32'(m_valid), 32'd1);
        chk("pre_reset_ram_rd_data_inflight", 32'(pend), 32'd1);
        rd_rst = 1'b1;
        wptr = 0;
        tick();
        chk("post_reset_m_valid", 32'(m_valid), 32'd0);
        chk("post_reset_rdaddr", 32'(rdaddr), 32'd0);
        chk("post_reset_rdaddr_gray", 32'(rdaddr_gray), 32'd0);
        chk("post_reset_m_data", 32'(m_data), 32'd0);
        rd_rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            m_ready = 1'($urandom_range(0, 1));
            tick();
        end
        chk("final_empty", 32'(empty), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
